// File: rtl/da_z1_accum_if.sv
// Request/result and coefficient-ROM bus of the Z1 distributed-arithmetic term
// unit. The master side is the environment (requester plus ROM). The slave side
// is the accumulator.
interface da_z1_accum_if #(
   parameter int SAMPLE_W = 8
);
   logic                       start;
   logic signed [SAMPLE_W-1:0] x0;
   logic signed [SAMPLE_W-1:0] x1;
   logic signed [SAMPLE_W-1:0] x2;
   logic signed [SAMPLE_W-1:0] x3;
   logic                       rom_cs;
   logic [2:0]                 rom_addr;
   logic signed [15:0]         rom_data;
   logic                       busy;
   logic                       done;
   logic signed [SAMPLE_W+16:0] y;

   modport master (
      output start, x0, x1, x2, x3, rom_data,
      input  rom_cs, rom_addr, busy, done, y
   );

   modport slave (
      input  start, x0, x1, x2, x3, rom_data,
      output rom_cs, rom_addr, busy, done, y
   );
endinterface

// File: rtl/da_z1_accum.sv
// Bit-serial distributed-arithmetic accumulator for one Z1 term.
// Four signed samples are processed MSB first, one bit-slice per cycle.
// The bits select an offset-binary ROM word, which is added into a
// shift-accumulator that is wide enough that no precision is lost.
// Optional build macro DA_ROM_CS_GATE_EN: when defined, rom_cs is asserted
// only while bit-slices are being processed. Otherwise it stays high whenever
// the block is out of reset.
module da_z1_accum #(
   parameter int SAMPLE_W = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   da_z1_accum_if.slave  bus
);
   localparam int         ACC_W   = SAMPLE_W + 17;
   localparam logic [3:0] CNT_MAX = 4'(SAMPLE_W - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                    state_q;
   logic [3:0]                cnt_q;
   logic [SAMPLE_W-1:0]       sr0_q, sr1_q, sr2_q, sr3_q;
   logic signed [ACC_W-1:0]   acc_q;
   logic signed [ACC_W-1:0]   y_q;
   logic                      busy_q, done_q, rom_cs_q, armed_q;

   logic                      b0, b1, b2, b3;
   logic                      in_run, accept, run_nxt;
   logic signed [16:0]        term;
   logic signed [ACC_W-1:0]   term_ext;
   logic signed [ACC_W-1:0]   acc_nxt;

   // Sign-extend the Q2.14 word by one bit before negating, so that -(-32768) fits.
   function automatic logic signed [16:0] sel_term(input logic neg, input logic signed [15:0] word);
      logic signed [16:0] w;
      w = {word[15], word};
      return neg ? -w : w;
   endfunction

   function automatic logic signed [ACC_W-1:0] sext_acc(input logic signed [16:0] t);
      return {{(ACC_W-17){t[16]}}, t};
   endfunction

   assign b0 = sr0_q[SAMPLE_W-1];
   assign b1 = sr1_q[SAMPLE_W-1];
   assign b2 = sr2_q[SAMPLE_W-1];
   assign b3 = sr3_q[SAMPLE_W-1];

   assign in_run  = (state_q == RUN);
   assign accept  = (state_q == IDLE) && bus.start && armed_q;
   assign run_nxt = accept || (in_run && (cnt_q != 4'd0));

   // Offset-binary addressing: a set x0 bit folds the table by inverting the other bits and negating the word.
   always_comb begin
      bus.rom_addr = 3'b000;
      if (in_run)
         bus.rom_addr = b0 ? ~{b1, b2, b3} : {b1, b2, b3};
   end

   assign term     = sel_term(b0, bus.rom_data);
   assign term_ext = sext_acc(term);
   // The MSB slice carries negative weight, so it seeds the accumulator with -T.
   assign acc_nxt  = (cnt_q == CNT_MAX) ? -term_ext : ((acc_q <<< 1) + term_ext);

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.y      = y_q;
   assign bus.rom_cs = rom_cs_q;

   // Control FSM, sample shifters, and accumulator. Every output is registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= 4'd0;
         sr0_q    <= '0;
         sr1_q    <= '0;
         sr2_q    <= '0;
         sr3_q    <= '0;
         acc_q    <= '0;
         y_q      <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         rom_cs_q <= 1'b0;
         armed_q  <= 1'b0;
      end else begin
         // The ROM output is unusable in the first cycle after reset release, so start is not armed until then.
         armed_q <= 1'b1;
`ifdef DA_ROM_CS_GATE_EN
         rom_cs_q <= run_nxt;
`else
         rom_cs_q <= 1'b1;
`endif
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  sr0_q   <= bus.x0;
                  sr1_q   <= bus.x1;
                  sr2_q   <= bus.x2;
                  sr3_q   <= bus.x3;
                  cnt_q   <= CNT_MAX;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end
            end
            RUN: begin
               acc_q <= acc_nxt;
               sr0_q <= sr0_q << 1;
               sr1_q <= sr1_q << 1;
               sr2_q <= sr2_q << 1;
               sr3_q <= sr3_q << 1;
               if (cnt_q == 4'd0) begin
                  y_q     <= acc_nxt;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            DONE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_da_z1_accum.sv
// Directed bench for da_z1_accum. It provides a combinational coefficient ROM
// built from four Q2.14 coefficients. The expected y values are hand-derived
// from y = sum(c_i * x_i) + sum(c_i) / 2.
module tb_da_z1_accum;
   localparam int W    = 8;
   localparam int C0   = 16796;
   localparam int C1   = 12000;
   localparam int C2   = 10000;
   localparam int C3   = 3196;
   localparam int OFFS = 20996;
`ifdef DA_ROM_CS_GATE_EN
   localparam logic GATED = 1'b1;
`else
   localparam logic GATED = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   da_z1_accum_if #(.SAMPLE_W(W)) bus ();
   da_z1_accum #(.SAMPLE_W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   function automatic logic signed [15:0] rom_word(input logic [2:0] a);
      int v;
      v = -C0 + (a[2] ? C1 : -C1) + (a[1] ? C2 : -C2) + (a[0] ? C3 : -C3);
      return 16'(v / 2);
   endfunction

   always_comb bus.rom_data = rom_word(bus.rom_addr);

   function automatic int ref_y(input int a, input int b, input int c, input int d);
      return C0 * a + C1 * b + C2 * c + C3 * d + OFFS;
   endfunction

   int passed = 0;
   int total  = 0;
   int obs_y, done_cnt, lat;
   logic [2:0] addr_log [0:31];
   logic       cs_log   [0:31];
   logic       busy_log [0:31];

   task automatic run_calc(input int a, input int b, input int c, input int d,
                           input int win, input int poke_at);
      bus.start = 1'b1;
      bus.x0 = W'(a); bus.x1 = W'(b); bus.x2 = W'(c); bus.x3 = W'(d);
      done_cnt = 0; lat = -1; obs_y = 0;
      for (int i = 1; i <= win; i++) begin
         @(posedge clk); #1;
         bus.start = (poke_at != 0) && (i == poke_at);
         if (i == poke_at) begin
            bus.x0 = 8'sd55; bus.x1 = -8'sd77; bus.x2 = 8'sd12; bus.x3 = -8'sd99;
         end
         addr_log[i] = bus.rom_addr;
         cs_log[i]   = bus.rom_cs;
         busy_log[i] = bus.busy;
         if (bus.done) begin
            done_cnt++;
            if (lat < 0) begin
               lat = i;
               obs_y = bus.y;
            end
         end
      end
      bus.start = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; bus.start = 1'b0;
      bus.x0 = '0; bus.x1 = '0; bus.x2 = '0; bus.x3 = '0;
      repeat (2) @(posedge clk); #1;
      total++; if (bus.y !== '0) $display("FAIL reset_y got %0d want 0", bus.y); else passed++;
      total++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done); else passed++;
      total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else passed++;
      total++; if (bus.rom_addr !== 3'd0) $display("FAIL reset_addr got %0d want 0", bus.rom_addr); else passed++;
      total++; if (bus.rom_cs !== 1'b0) $display("FAIL reset_cs got %b want 0", bus.rom_cs); else passed++;
      rst_n = 1'b1; bus.start = 1'b1; bus.x0 = 8'sd3;
      @(posedge clk); #1;
      bus.start = 1'b0;
      total++; if (bus.busy !== 1'b0) $display("FAIL start_after_release got busy %b want 0", bus.busy); else passed++;
      @(posedge clk); #1;
      total++; if (bus.busy !== 1'b0) $display("FAIL idle_busy got %b want 0", bus.busy); else passed++;
      total++; if (bus.rom_cs !== ~GATED) $display("FAIL idle_cs got %b want %b", bus.rom_cs, ~GATED); else passed++;
   endtask

   task automatic test_zero;
      run_calc(0, 0, 0, 0, 10, 0);
      total++; if (obs_y !== 20996) $display("FAIL zero_y got %0d want 20996", obs_y); else passed++;
      total++; if (lat !== 9) $display("FAIL zero_latency got %0d want 9", lat); else passed++;
      total++; if (done_cnt !== 1) $display("FAIL zero_done_pulses got %0d want 1", done_cnt); else passed++;
      for (int k = 1; k <= 8; k++) begin
         total++; if (addr_log[k] !== 3'd0) $display("FAIL zero_addr cycle %0d got %0d want 0", k, addr_log[k]); else passed++;
      end
      total++; if (busy_log[1] !== 1'b1) $display("FAIL run_busy got %b want 1", busy_log[1]); else passed++;
      total++; if (busy_log[9] !== 1'b1) $display("FAIL done_busy got %b want 1", busy_log[9]); else passed++;
      total++; if (busy_log[10] !== 1'b0) $display("FAIL post_busy got %b want 0", busy_log[10]); else passed++;
      total++; if (cs_log[4] !== 1'b1) $display("FAIL run_cs got %b want 1", cs_log[4]); else passed++;
      total++; if (cs_log[9] !== ~GATED) $display("FAIL done_cs got %b want %b", cs_log[9], ~GATED); else passed++;
      total++; if (cs_log[10] !== ~GATED) $display("FAIL idle_cs2 got %b want %b", cs_log[10], ~GATED); else passed++;
      total++; if (addr_log[9] !== 3'd0) $display("FAIL done_addr got %0d want 0", addr_log[9]); else passed++;
      @(posedge clk); #1;
      total++; if (bus.y !== 25'sd20996) $display("FAIL y_hold got %0d want 20996", bus.y); else passed++;
   endtask

   task automatic test_all_ones;
      run_calc(-1, -1, -1, -1, 10, 0);
      total++; if (obs_y !== -20996) $display("FAIL ones_y got %0d want -20996", obs_y); else passed++;
      for (int k = 1; k <= 8; k++) begin
         total++; if (addr_log[k] !== 3'd0) $display("FAIL ones_addr cycle %0d got %0d want 0", k, addr_log[k]); else passed++;
      end
   endtask

   task automatic test_x3_one;
      run_calc(0, 0, 0, 1, 10, 0);
      total++; if (obs_y !== 24192) $display("FAIL x3_y got %0d want 24192", obs_y); else passed++;
      total++; if (addr_log[8] !== 3'd1) $display("FAIL x3_last_addr got %0d want 1", addr_log[8]); else passed++;
      total++; if (addr_log[7] !== 3'd0) $display("FAIL x3_prev_addr got %0d want 0", addr_log[7]); else passed++;
   endtask

   task automatic test_directed;
      run_calc(1, 0, 0, 0, 10, 0);
      total++; if (obs_y !== 37792) $display("FAIL x0_one_y got %0d want 37792", obs_y); else passed++;
      total++; if (addr_log[8] !== 3'd7) $display("FAIL x0_one_addr got %0d want 7", addr_log[8]); else passed++;
      run_calc(-128, 127, -128, 127, 10, 0);
      total++; if (obs_y !== -1479000) $display("FAIL extreme_y got %0d want -1479000", obs_y); else passed++;
   endtask

   task automatic test_start_during_run;
      run_calc(0, 0, 0, 1, 14, 3);
      total++; if (obs_y !== 24192) $display("FAIL ignore_start_y got %0d want 24192", obs_y); else passed++;
      total++; if (done_cnt !== 1) $display("FAIL ignore_start_pulses got %0d want 1", done_cnt); else passed++;
      total++; if (lat !== 9) $display("FAIL ignore_start_latency got %0d want 9", lat); else passed++;
   endtask

   task automatic test_back_to_back;
      run_calc(1, 0, 0, 0, 10, 0);
      total++; if (obs_y !== 37792) $display("FAIL b2b_first_y got %0d want 37792", obs_y); else passed++;
      run_calc(0, 0, 0, 1, 10, 0);
      total++; if (lat !== 9) $display("FAIL b2b_latency got %0d want 9", lat); else passed++;
      total++; if (obs_y !== 24192) $display("FAIL b2b_second_y got %0d want 24192", obs_y); else passed++;
   endtask

   task automatic test_reset_mid_run;
      int dn;
      run_calc(-1, -1, -1, -1, 5, 0);
      rst_n = 1'b0; #1;
      total++; if (bus.y !== '0) $display("FAIL abort_y got %0d want 0", bus.y); else passed++;
      total++; if (bus.busy !== 1'b0) $display("FAIL abort_busy got %b want 0", bus.busy); else passed++;
      total++; if (bus.done !== 1'b0) $display("FAIL abort_done got %b want 0", bus.done); else passed++;
      total++; if (bus.rom_addr !== 3'd0) $display("FAIL abort_addr got %0d want 0", bus.rom_addr); else passed++;
      total++; if (bus.rom_cs !== 1'b0) $display("FAIL abort_cs got %b want 0", bus.rom_cs); else passed++;
      dn = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         if (bus.done) dn++;
      end
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (bus.done) dn++;
      end
      total++; if (dn !== 0) $display("FAIL abort_done_pulses got %0d want 0", dn); else passed++;
      run_calc(2, -3, 4, -5, 10, 0);
      total++; if (obs_y !== 42608) $display("FAIL after_abort_y got %0d want 42608", obs_y); else passed++;
   endtask

   task automatic test_random;
      logic signed [W-1:0] r0, r1, r2, r3;
      for (int n = 0; n < 1000; n++) begin
         r0 = W'($urandom); r1 = W'($urandom); r2 = W'($urandom); r3 = W'($urandom);
         run_calc(r0, r1, r2, r3, 10, 0);
         total++;
         if (obs_y !== ref_y(r0, r1, r2, r3) || done_cnt !== 1 || cs_log[9] !== ~GATED)
            $display("FAIL random_%0d got y %0d pulses %0d cs %b want y %0d pulses 1 cs %b",
                     n, obs_y, done_cnt, cs_log[9], ref_y(r0, r1, r2, r3), ~GATED);
         else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_zero();
      test_all_ones();
      test_x3_one();
      test_directed();
      test_start_during_run();
      test_back_to_back();
      test_reset_mid_run();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
